// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory responder: FSM states, access op and the
// request captured on the accept edge.
package cpu_mem_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    // lanes is active-high: lanes[1] = upper byte, lanes[0] = lower byte
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        op_t               op;
        logic [1:0]        lanes;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word array with per-byte write enables and a registered read.
// rdata only changes on a read, so it holds the last read word across writes.
module mem_word_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 Clk,
    input  logic                 en,
    input  logic                 wr,
    input  logic [1:0]           be,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge Clk) begin
        if (en) begin
            if (wr) begin
                if (be[1]) mem[addr][15:8] <= wdata[15:8];
                if (be[0]) mem[addr][7:0]  <= wdata[7:0];
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// SRAM-style bus responder: accepts an access, waits WAIT_CYCLES, commits it
// to the word array and pulses mem_ready. Optional access counters are built
// when CPU_MEM_RESPONDER_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for CE low with OE or WE low
// WAIT  | access latched, counting down wait states
// HOLD  | access served; waits for the bus to release or change
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A,
    input  logic [WORD_W-1:0] Data_out,
    input  logic              CE,
    input  logic              OE,
    input  logic              WE,
    input  logic              UB,
    input  logic              LB,
    output logic [WORD_W-1:0] Data_in,
    output logic              mem_ready
`ifdef CPU_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    mem_req_t          req_q, req_d;
    logic              ready_d;
    logic [1:0]        rd_mask_q, rd_mask_d;
    logic              mem_en;
    logic [WORD_W-1:0] mem_rdata;
    logic              req_active;
    op_t               cur_op;

    assign req_active = !CE && (!OE || !WE);
    assign cur_op     = !WE ? OP_WRITE : OP_READ;

    // Upper address bits alias away; they are latched only to keep the struct whole.
    logic addr_hi_unused;
    assign addr_hi_unused = ^req_q.addr[ADDR_W-1:ADDR_BITS];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        rd_mask_d  = rd_mask_q;
        ready_d    = 1'b0;
        mem_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_active) begin
                    req_d.addr  = A;
                    req_d.op    = cur_op;
                    req_d.lanes = {~UB, ~LB};
                    req_d.wdata = Data_out;
                    wait_cnt_d  = 4'(WAIT_CYCLES);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    // Gated by Reset so an aborted write never reaches the array
                    mem_en  = !Reset;
                    ready_d = 1'b1;
                    state_d = HOLD;
                    if (req_q.op == OP_READ) rd_mask_d = req_q.lanes;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (!req_active
                    || (A[ADDR_BITS-1:0] != req_q.addr[ADDR_BITS-1:0])
                    || (cur_op != req_q.op)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            req_q      <= '0;
            rd_mask_q  <= 2'b00;
            mem_ready  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            req_q      <= req_d;
            rd_mask_q  <= rd_mask_d;
            mem_ready  <= ready_d;
        end
    end

    mem_word_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .Clk   (Clk),
        .en    (mem_en),
        .wr    (req_q.op == OP_WRITE),
        .be    (req_q.lanes),
        .addr  (req_q.addr[ADDR_BITS-1:0]),
        .wdata (req_q.wdata),
        .rdata (mem_rdata)
    );

    // Lane mask of the last completed read; cleared by reset so Data_in reads zero
    assign Data_in = {rd_mask_q[1] ? mem_rdata[15:8] : 8'h00,
                      rd_mask_q[0] ? mem_rdata[7:0]  : 8'h00};

`ifdef CPU_MEM_RESPONDER_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else if (ready_d) begin
            if (req_q.op == OP_READ) rd_count <= rd_count + 16'd1;
            else                     wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: expected responses are queued when
// an access is driven and checked when mem_ready is observed.
module tb_cpu_mem_responder;

    localparam int WAIT_N = 2;
    localparam int ABITS  = 10;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [19:0] A = '0;
    logic [15:0] Data_out = '0;
    logic        CE = 1'b1, OE = 1'b1, WE = 1'b1, UB = 1'b1, LB = 1'b1;
    logic [15:0] Data_in;
    logic        mem_ready;
`ifdef CPU_MEM_RESPONDER_STATS_EN
    logic [15:0] rd_count, wr_count;
`endif

    cpu_mem_responder #(
        .ADDR_BITS   (ABITS),
        .WAIT_CYCLES (WAIT_N)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .A         (A),
        .Data_out  (Data_out),
        .CE        (CE),
        .OE        (OE),
        .WE        (WE),
        .UB        (UB),
        .LB        (LB),
        .Data_in   (Data_in),
        .mem_ready (mem_ready)
`ifdef CPU_MEM_RESPONDER_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        is_read;
        logic [15:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] model [1024];
    int          cyc = 0;
    int          ready_seen = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [15:0] last_rd = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (!Reset && mem_ready) begin
            ready_seen++;
            if (sb.size() == 0) begin
                chk("spurious_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", 32'(cyc - mon_e.acc), 32'(WAIT_N + 1));
                if (mon_e.is_read) chk("rdata", {16'h0, Data_in}, {16'h0, mon_e.data});
            end
        end
    end

    task automatic access(input logic wr, input logic [19:0] addr, input logic [15:0] wd,
                          input logic ub, input logic lb, input int hold_extra);
        exp_t e;
        int   seen0;
        int   k;
        logic [9:0] idx;
        idx = addr[9:0];
        @(negedge Clk);
        A = addr; Data_out = wd; UB = ub; LB = lb; CE = 1'b0;
        OE = wr; WE = !wr;
        e.is_read = !wr;
        e.acc = cyc + 1;
        if (wr) begin
            if (!ub) model[idx][15:8] = wd[15:8];
            if (!lb) model[idx][7:0]  = wd[7:0];
            e.data = 16'h0000;
            n_wr++;
        end else begin
            e.data = {ub ? 8'h00 : model[idx][15:8], lb ? 8'h00 : model[idx][7:0]};
            last_rd = e.data;
            n_rd++;
        end
        sb.push_back(e);
        seen0 = ready_seen;
        k = 0;
        while (ready_seen == seen0 && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (ready_seen == seen0) chk("ready_timeout", 32'd0, 32'd1);
        repeat (hold_extra) @(negedge Clk);
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_ready", {31'h0, mem_ready}, 32'd0);
        chk("rst_din", {16'h0, Data_in}, 32'h0);
        Reset = 1'b0;
        @(negedge Clk);

        access(1'b1, 20'h00010, 16'h2C07, 1'b0, 1'b0, 0);
        access(1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 10);
        chk("rd_2c07", {16'h0, Data_in}, 32'h2C07);

        access(1'b1, 20'h00010, 16'hABCD, 1'b1, 1'b0, 0);
        access(1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 0);
        chk("rd_2ccd", {16'h0, Data_in}, 32'h2CCD);
        access(1'b0, 20'h00010, 16'h0000, 1'b0, 1'b1, 0);
        chk("rd_upper_only", {16'h0, Data_in}, 32'h2C00);

        access(1'b1, 20'h00003, 16'h3A07, 1'b0, 1'b0, 0);
        access(1'b0, 20'h00403, 16'h0000, 1'b0, 1'b0, 0);
        chk("alias_403", {16'h0, Data_in}, 32'h3A07);
        access(1'b1, 20'h003FF, 16'h5A5A, 1'b0, 1'b0, 0);
        access(1'b0, 20'hFFFFF, 16'h0000, 1'b0, 1'b0, 0);
        chk("wrap_fffff", {16'h0, Data_in}, 32'h5A5A);
        access(1'b1, 20'h00400, 16'hBEEF, 1'b0, 1'b0, 0);
        access(1'b0, 20'h00000, 16'h0000, 1'b1, 1'b0, 0);
        chk("alias_400_lo", {16'h0, Data_in}, 32'h00EF);

        access(1'b1, 20'h00010, 16'h9999, 1'b1, 1'b1, 0);
        chk("din_hold_noop", {16'h0, Data_in}, {16'h0, last_rd});
        access(1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 0);
        chk("noop_kept", {16'h0, Data_in}, 32'h2CCD);

        access(1'b1, 20'h00020, 16'h0000, 1'b0, 1'b0, 0);
        @(negedge Clk);
        A = 20'h00020; Data_out = 16'h1111; UB = 1'b0; LB = 1'b0;
        CE = 1'b0; OE = 1'b1; WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        CE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_din", {16'h0, Data_in}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("abort_ready", {31'h0, mem_ready}, 32'd0);
        end
        access(1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, 0);
        chk("abort_discard", {16'h0, Data_in}, 32'h0000);

        repeat (5) @(negedge Clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
`ifdef CPU_MEM_RESPONDER_STATS_EN
        chk("wr_count", {16'h0, wr_count}, 32'(n_wr));
        chk("rd_count", {16'h0, rd_count}, 32'(n_rd));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
